freq_meas_ctrl: RTL and testbench

//  Auto-ranging sequencer for the equal-precision period counter (N-edge gate, 200 MHz timestamp).

---
 rtl/freq_meas_ctrl.sv | 149 ++++++++++++++
 tb/tb_freq_meas_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meas_ctrl.sv
// Auto-ranging sequencer for an equal-precision period counter: arms a gate of N edges,
// re-ranges N by x4 or /4 to keep the tick count within a window, and detects a missing signal.
module freq_meas_ctrl #(
    parameter logic [15:0] N_INIT      = 16'd1,
    parameter logic [15:0] N_MAX       = 16'd4096,
    parameter logic [31:0] TICKS_LO    = 32'd2_000_000,
    parameter logic [31:0] TICKS_HI    = 32'd40_000_000,
    parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000,
    parameter logic [7:0]  SETTLE_CYC  = 8'd8,
    parameter logic [2:0]  RANGE_TRIES = 3'd4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        cont_mode,
    input  logic        abort,
    output logic        meas_start,
    output logic [15:0] meas_n,
    input  logic        meas_done,
    input  logic [31:0] meas_ticks,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_n,
    output logic [31:0] res_ticks,
    output logic        res_timeout,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_EVAL,
        S_OUT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_settle;
    logic [31:0] r_tmo;
    logic [2:0]  r_try;
    logic [15:0] r_meas_n;
    logic        r_meas_start;
    logic [31:0] r_ticks;
    logic [15:0] r_res_n;
    logic [31:0] r_res_ticks;
    logic        r_res_timeout;

    logic        w_settle_done;
    logic        w_tmo_hit;
    logic [17:0] w_n_up_wide;
    logic [15:0] w_n_up;
    logic [15:0] w_n_shr;
    logic [15:0] w_n_dn;
    logic        w_tries_left;
    logic        w_go_up;
    logic        w_go_dn;

    assign w_settle_done = (r_settle == SETTLE_CYC);
    assign w_tmo_hit     = (r_tmo == TIMEOUT_CYC - 32'd1);

    // Widen before the x4 step so N_MAX clamping sees the true product.
    assign w_n_up_wide   = {2'b00, r_meas_n} << 2;
    assign w_n_up        = (w_n_up_wide > {2'b00, N_MAX}) ? N_MAX : w_n_up_wide[15:0];
    assign w_n_shr       = r_meas_n >> 2;
    assign w_n_dn        = (w_n_shr == 16'd0) ? 16'd1 : w_n_shr;

    assign w_tries_left  = (r_try < RANGE_TRIES);
    assign w_go_up       = w_tries_left && (r_ticks < TICKS_LO) && (r_meas_n < N_MAX);
    assign w_go_dn       = w_tries_left && (r_ticks > TICKS_HI) && (r_meas_n > 16'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (start)         w_state_nxt = S_ARM;
            S_ARM:  if (w_settle_done) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (meas_done)      w_state_nxt = S_EVAL;
                else if (w_tmo_hit) w_state_nxt = S_OUT;
            end
            S_EVAL: w_state_nxt = (w_go_up || w_go_dn) ? S_ARM : S_OUT;
            S_OUT:  if (res_ready) w_state_nxt = cont_mode ? S_ARM : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_settle      <= 8'd0;
            r_tmo         <= 32'd0;
            r_try         <= 3'd0;
            r_meas_n      <= N_INIT;
            r_meas_start  <= 1'b0;
            r_ticks       <= 32'd0;
            r_res_n       <= 16'd0;
            r_res_ticks   <= 32'd0;
            r_res_timeout <= 1'b0;
        end else begin
            r_meas_start <= (r_state == S_ARM) && (w_state_nxt == S_WAIT);
            r_settle     <= ((r_state == S_ARM) && (w_state_nxt == S_ARM)) ? r_settle + 8'd1 : 8'd0;
            r_tmo        <= ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) ? r_tmo + 32'd1 : 32'd0;

            // Try count survives only across EVAL->ARM re-ranges of one measurement.
            if (w_state_nxt == S_IDLE || r_state == S_IDLE || r_state == S_OUT)
                r_try <= 3'd0;
            else if (r_state == S_EVAL && w_state_nxt == S_ARM)
                r_try <= r_try + 3'd1;

            if (!abort) begin
                if (r_state == S_WAIT) begin
                    if (meas_done) begin
                        r_ticks <= meas_ticks;
                    end else if (w_tmo_hit) begin
                        r_res_n       <= r_meas_n;
                        r_res_ticks   <= 32'd0;
                        r_res_timeout <= 1'b1;
                        r_meas_n      <= N_INIT;
                    end
                end else if (r_state == S_EVAL) begin
                    if (w_go_up) begin
                        r_meas_n <= w_n_up;
                    end else if (w_go_dn) begin
                        r_meas_n <= w_n_dn;
                    end else begin
                        r_res_n       <= r_meas_n;
                        r_res_ticks   <= r_ticks;
                        r_res_timeout <= 1'b0;
                    end
                end
            end
        end
    end

    assign meas_start  = r_meas_start;
    assign meas_n      = r_meas_n;
    assign res_valid   = (r_state == S_OUT);
    assign res_n       = r_res_n;
    assign res_ticks   = r_res_ticks;
    assign res_timeout = r_res_timeout;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Self-checking bench for freq_meas_ctrl: scenario tasks plus randomized ranging runs
// checked against a behavioural model of the N selection rules.
module tb_freq_meas_ctrl;

    localparam int     SETTLE = 8;
    localparam int     TMO    = 300;
    localparam int     TRIES  = 4;
    localparam int     NMAX   = 4096;
    localparam int     NINIT  = 1;
    localparam int     LIM    = 2000;
    localparam longint LO     = 2_000_000;
    localparam longint HI     = 40_000_000;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start;
    logic        cont_mode;
    logic        abort;
    logic        meas_start;
    logic [15:0] meas_n;
    logic        meas_done;
    logic [31:0] meas_ticks;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_n;
    logic [31:0] res_ticks;
    logic        res_timeout;
    logic        busy;

    int          passed = 0;
    int          total  = 0;
    int          m_n;
    logic [31:0] stim_q[$];

    freq_meas_ctrl #(
        .TIMEOUT_CYC(32'd300)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .cont_mode  (cont_mode),
        .abort      (abort),
        .meas_start (meas_start),
        .meas_n     (meas_n),
        .meas_done  (meas_done),
        .meas_ticks (meas_ticks),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_n      (res_n),
        .res_ticks  (res_ticks),
        .res_timeout(res_timeout),
        .busy       (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model of one evaluation: returns the N for the next gate, or accepts.
    function automatic void model_eval(input longint t, inout int n, inout int tries, output bit accept);
        accept = 1'b0;
        if (tries < TRIES && t < LO && n < NMAX) begin
            n = (n * 4 > NMAX) ? NMAX : n * 4;
            tries++;
        end else if (tries < TRIES && t > HI && n > 1) begin
            n = (n / 4 < 1) ? 1 : n / 4;
            tries++;
        end else begin
            accept = 1'b1;
        end
    endfunction

    task automatic pulse_start();
        @(negedge sys_clk);
        start = 1'b1;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_meas_start(input string tag, output int lat, output bit found);
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < LIM; i++) begin
            @(posedge sys_clk);
            #1;
            if (meas_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            lat++;
        end
        if (!found) begin
            total++;
            $display("FAIL %s: meas_start not seen within %0d cycles", tag, LIM);
        end
    endtask

    task automatic wait_res(input string tag, output int lat, output bit found);
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < LIM; i++) begin
            @(posedge sys_clk);
            #1;
            if (res_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            lat++;
        end
        if (!found) begin
            total++;
            $display("FAIL %s: res_valid not seen within %0d cycles", tag, LIM);
        end
    endtask

    task automatic give_done(input logic [31:0] t);
        meas_ticks = t;
        meas_done  = 1'b1;
        @(posedge sys_clk);
        #1;
        meas_done  = 1'b0;
    endtask

    task automatic handshake(input int hold);
        repeat (hold) @(posedge sys_clk);
        #1;
        res_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        res_ready = 1'b0;
    endtask

    // One full measurement (possibly several re-ranges) in single-shot mode.
    task automatic run_seq(input string tag);
        int          lat;
        bit          found;
        bit          acc;
        int          tries;
        int          idx;
        logic [31:0] t;
        tries = 0;
        idx   = 0;
        acc   = 1'b0;
        t     = 32'd0;
        pulse_start();
        while (!acc) begin
            wait_meas_start(tag, lat, found);
            if (!found) return;
            total++;
            if (meas_n !== 16'(m_n))
                $display("FAIL %s meas_n: got %0d expected %0d", tag, meas_n, m_n);
            else passed++;
            t = stim_q[(idx < stim_q.size()) ? idx : stim_q.size() - 1];
            idx++;
            repeat ($urandom_range(0, 40)) @(posedge sys_clk);
            #1;
            give_done(t);
            model_eval(t, m_n, tries, acc);
        end
        wait_res(tag, lat, found);
        if (!found) return;
        total++;
        if (res_n !== 16'(m_n) || res_ticks !== t || res_timeout !== 1'b0)
            $display("FAIL %s result: got n=%0d ticks=%0d to=%0b expected n=%0d ticks=%0d to=0",
                     tag, res_n, res_ticks, res_timeout, m_n, t);
        else passed++;
        handshake($urandom_range(0, 5));
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s release: got valid=%0b busy=%0b expected 0/0", tag, res_valid, busy);
        else passed++;
    endtask

    task automatic test_reset();
        sys_rst_n  = 1'b0;
        start      = 1'b0;
        cont_mode  = 1'b0;
        abort      = 1'b0;
        meas_done  = 1'b0;
        meas_ticks = 32'd0;
        res_ready  = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        m_n = NINIT;
        total++; if (meas_start !== 1'b0) $display("FAIL reset meas_start: got %0b expected 0", meas_start); else passed++;
        total++; if (meas_n !== 16'd1) $display("FAIL reset meas_n: got %0d expected 1", meas_n); else passed++;
        total++; if (res_valid !== 1'b0) $display("FAIL reset res_valid: got %0b expected 0", res_valid); else passed++;
        total++; if (res_n !== 16'd0) $display("FAIL reset res_n: got %0d expected 0", res_n); else passed++;
        total++; if (res_ticks !== 32'd0) $display("FAIL reset res_ticks: got %0d expected 0", res_ticks); else passed++;
        total++; if (res_timeout !== 1'b0) $display("FAIL reset res_timeout: got %0b expected 0", res_timeout); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset busy: got %0b expected 0", busy); else passed++;
    endtask

    task automatic test_basic();
        int lat;
        bit found;
        pulse_start();
        total++; if (busy !== 1'b1) $display("FAIL basic busy: got %0b expected 1", busy); else passed++;
        wait_meas_start("basic", lat, found);
        if (!found) return;
        total++; if (lat !== SETTLE) $display("FAIL basic settle: got %0d expected %0d", lat, SETTLE); else passed++;
        total++; if (meas_n !== 16'd1) $display("FAIL basic meas_n: got %0d expected 1", meas_n); else passed++;
        @(posedge sys_clk);
        #1;
        total++; if (meas_start !== 1'b0) $display("FAIL basic pulse width: got %0b expected 0", meas_start); else passed++;
        repeat (98) @(posedge sys_clk);
        #1;
        give_done(32'd5_000_000);
        wait_res("basic", lat, found);
        if (!found) return;
        total++;
        if (res_n !== 16'd1 || res_ticks !== 32'd5_000_000 || res_timeout !== 1'b0)
            $display("FAIL basic result: got n=%0d ticks=%0d to=%0b expected 1/5000000/0", res_n, res_ticks, res_timeout);
        else passed++;
        handshake(3);
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic release: got valid=%0b busy=%0b expected 0/0", res_valid, busy);
        else passed++;
    endtask

    task automatic test_upscale();
        stim_q = '{32'd10_000};
        run_seq("upscale");
        total++; if (res_n !== 16'd256) $display("FAIL upscale res_n: got %0d expected 256", res_n); else passed++;
        total++; if (meas_n !== 16'd256) $display("FAIL upscale memory: got %0d expected 256", meas_n); else passed++;
    endtask

    task automatic test_downscale();
        stim_q = '{32'd10_000};
        run_seq("clamp_up");
        total++; if (meas_n !== 16'd4096) $display("FAIL clamp meas_n: got %0d expected 4096", meas_n); else passed++;
        stim_q = '{32'd100_000_000, 32'd25_000_000};
        run_seq("down_1024");
        total++; if (res_n !== 16'd1024) $display("FAIL down res_n: got %0d expected 1024", res_n); else passed++;
        stim_q = '{32'd100_000_000};
        run_seq("down_multi");
        run_seq("floor_1");
        total++;
        if (res_n !== 16'd1 || res_ticks !== 32'd100_000_000)
            $display("FAIL floor result: got n=%0d ticks=%0d expected 1/100000000", res_n, res_ticks);
        else passed++;
    endtask

    task automatic test_timeout();
        int lat;
        bit found;
        stim_q = '{32'd10_000};
        run_seq("pre_timeout");
        pulse_start();
        wait_meas_start("timeout", lat, found);
        if (!found) return;
        wait_res("timeout", lat, found);
        if (!found) return;
        total++; if (lat !== TMO - 1) $display("FAIL timeout latency: got %0d expected %0d", lat, TMO - 1); else passed++;
        total++;
        if (res_timeout !== 1'b1 || res_ticks !== 32'd0 || res_n !== 16'(m_n))
            $display("FAIL timeout result: got to=%0b ticks=%0d n=%0d expected 1/0/%0d", res_timeout, res_ticks, res_n, m_n);
        else passed++;
        m_n = NINIT;
        total++; if (meas_n !== 16'(m_n)) $display("FAIL timeout meas_n: got %0d expected %0d", meas_n, m_n); else passed++;
        handshake(2);
        pulse_start();
        wait_meas_start("tmo_race", lat, found);
        if (!found) return;
        repeat (TMO - 1) @(posedge sys_clk);
        #1;
        give_done(32'd5_000_000);
        wait_res("tmo_race", lat, found);
        if (!found) return;
        total++;
        if (res_timeout !== 1'b0 || res_ticks !== 32'd5_000_000 || res_n !== 16'd1)
            $display("FAIL race result: got to=%0b ticks=%0d n=%0d expected 0/5000000/1", res_timeout, res_ticks, res_n);
        else passed++;
        handshake(1);
    endtask

    task automatic test_cont_mode();
        int          lat;
        bit          found;
        int          bad;
        logic [48:0] snap;
        cont_mode = 1'b1;
        pulse_start();
        wait_meas_start("cont", lat, found);
        if (!found) return;
        give_done(32'd5_000_000);
        wait_res("cont", lat, found);
        if (!found) return;
        snap = {res_n, res_ticks, res_timeout};
        bad  = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk);
            #1;
            if (res_valid !== 1'b1 || {res_n, res_ticks, res_timeout} !== snap || meas_start !== 1'b0) bad++;
        end
        total++; if (bad !== 0) $display("FAIL cont hold: got %0d bad cycles expected 0", bad); else passed++;
        total++;
        if (res_n !== 16'd1 || res_ticks !== 32'd5_000_000)
            $display("FAIL cont result: got n=%0d ticks=%0d expected 1/5000000", res_n, res_ticks);
        else passed++;
        res_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL cont rearm state: got valid=%0b busy=%0b expected 0/1", res_valid, busy);
        else passed++;
        wait_meas_start("cont_rearm", lat, found);
        if (!found) return;
        total++; if (lat !== SETTLE) $display("FAIL cont rearm latency: got %0d expected %0d", lat, SETTLE); else passed++;
        cont_mode = 1'b0;
        give_done(32'd5_000_000);
        wait_res("cont_last", lat, found);
        if (!found) return;
        handshake(0);
        total++; if (busy !== 1'b0) $display("FAIL cont stop busy: got %0b expected 0", busy); else passed++;
    endtask

    task automatic test_abort();
        int lat;
        bit found;
        int bad;
        pulse_start();
        wait_meas_start("abort", lat, found);
        if (!found) return;
        repeat (5) @(posedge sys_clk);
        #1;
        abort      = 1'b1;
        meas_done  = 1'b1;
        meas_ticks = 32'd10_000;
        @(posedge sys_clk);
        #1;
        abort     = 1'b0;
        meas_done = 1'b0;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || meas_start !== 1'b0)
            $display("FAIL abort state: got busy=%0b valid=%0b start=%0b expected 0/0/0", busy, res_valid, meas_start);
        else passed++;
        total++; if (meas_n !== 16'(m_n)) $display("FAIL abort meas_n: got %0d expected %0d", meas_n, m_n); else passed++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge sys_clk);
            #1;
            if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        @(negedge sys_clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        if (busy !== 1'b0) bad++;
        pulse_start();
        repeat (3) @(posedge sys_clk);
        #1;
        abort = 1'b1;
        @(posedge sys_clk);
        #1;
        abort = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk);
            #1;
            if (meas_start !== 1'b0 || busy !== 1'b0) bad++;
        end
        total++; if (bad !== 0) $display("FAIL abort idle hold: got %0d bad cycles expected 0", bad); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] t;
        for (int it = 0; it < 10; it++) begin
            stim_q.delete();
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                case ($urandom_range(0, 3))
                    0:       t = $urandom_range(1, 1_999_999);
                    1:       t = $urandom_range(2_000_000, 40_000_000);
                    2:       t = $urandom_range(40_000_001, 400_000_000);
                    default: begin
                        case ($urandom_range(0, 3))
                            0:       t = 32'd2_000_000;
                            1:       t = 32'd40_000_000;
                            2:       t = 32'd1_999_999;
                            default: t = 32'd40_000_001;
                        endcase
                    end
                endcase
                stim_q.push_back(t);
            end
            run_seq("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_upscale();
        test_downscale();
        test_timeout();
        test_cont_mode();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
